// File: rtl/lcd_frame_driver.sv
// rtl/lcd_frame_driver.sv - character LCD refresh engine: power-up wait, init commands, continuous frame-buffer refresh
module lcd_frame_driver #(
    parameter int CLK_DIV  = 3,
    parameter int E_HIGH   = 1,
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int PWR_WAIT = 4,
    parameter int CLR_WAIT = 2,
    localparam int CELLS   = ROWS * COLS,
    localparam int AW      = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          reinit,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic          LCD_E,
    output logic [7:0]    LCD_DATA,
    output logic          init_done,
    output logic          frame_done
);

    localparam int DW   = $clog2(CLK_DIV);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WMAX = ((PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT) + 1;
    localparam int WW   = $clog2(WMAX + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] E_LAST   = DW'(E_HIGH);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [WW-1:0] PWR_LAST = WW'((PWR_WAIT > 0) ? PWR_WAIT - 1 : 0);
    localparam logic [WW-1:0] CLR_N    = WW'(CLR_WAIT);
    localparam logic [AW:0]   CELLS_W  = (AW+1)'(CELLS);

    typedef enum logic [1:0] {PWRUP, INIT, ADDR, CHAR} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [2:0]      idx_q, idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            e_q, e_d;
    logic            init_done_q, init_done_d;
    logic            frame_done_q, frame_done_d;
    logic            reinit_q, reinit_d;
    logic            step_end;
    logic [7:0]      buf_q [CELLS];

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0, 3'd1: return 8'h38;
            3'd2:       return 8'h0C;
            3'd3:       return 8'h01;
            default:    return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [RW-1:0] r);
        case (2'(r))
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    function automatic logic [AW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    assign step_end = (div_q == DIV_LAST);

    // The bus for the coming step is computed at the edge that starts it, so it holds for the full step.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        rs_d         = rs_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        reinit_d     = reinit_q | reinit;
        div_d        = step_end ? '0 : div_q + 1'b1;
        e_d          = (div_d != '0) && (div_d <= E_LAST);
        if (step_end) begin
            reinit_d = 1'b0;
            if (reinit_q || reinit) begin
                state_d     = INIT;
                idx_d       = '0;
                wait_d      = '0;
                rs_d        = 1'b0;
                data_d      = init_cmd(3'd0);
                init_done_d = 1'b0;
            end else begin
                case (state_q)
                    PWRUP: begin
                        if (wait_q >= PWR_LAST) begin
                            state_d = INIT;
                            idx_d   = '0;
                            wait_d  = '0;
                            rs_d    = 1'b0;
                            data_d  = init_cmd(3'd0);
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                    INIT: begin
                        if (idx_q == 3'd3 && wait_q < CLR_N) begin
                            wait_d = wait_q + 1'b1;
                        end else if (idx_q == 3'd4) begin
                            state_d     = ADDR;
                            row_d       = '0;
                            init_done_d = 1'b1;
                            rs_d        = 1'b0;
                            data_d      = addr_cmd('0);
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            wait_d = '0;
                            rs_d   = 1'b0;
                            data_d = init_cmd(idx_d);
                        end
                    end
                    ADDR: begin
                        state_d      = CHAR;
                        col_d        = '0;
                        rs_d         = 1'b1;
                        data_d       = buf_q[cell_idx(row_q, '0)];
                        frame_done_d = (row_q == ROW_LAST) && (COLS == 1);
                    end
                    CHAR: begin
                        if (col_q == COL_LAST) begin
                            state_d = ADDR;
                            col_d   = '0;
                            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                            rs_d    = 1'b0;
                            data_d  = addr_cmd(row_d);
                        end else begin
                            col_d        = col_q + 1'b1;
                            rs_d         = 1'b1;
                            data_d       = buf_q[cell_idx(row_q, col_d)];
                            frame_done_d = (row_q == ROW_LAST) && (col_d == COL_LAST);
                        end
                    end
                    default: state_d = PWRUP;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PWRUP;
            div_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            e_q          <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            reinit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            row_q        <= row_d;
            col_q        <= col_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            e_q          <= e_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            reinit_q     <= reinit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) buf_q[i] <= 8'h20;
        end else if (wr_en && ({1'b0, wr_addr} < CELLS_W)) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_E      = e_q;
    assign LCD_DATA   = data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_driver.sv
// tb/tb_lcd_frame_driver.sv - self-checking bench for lcd_frame_driver (default and 4x20 slow-clock instances)
module tb_lcd_frame_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en_a = 1'b0, reinit_a = 1'b0;
    logic [4:0] wr_addr_a = '0;
    logic [7:0] wr_data_a = '0;
    logic       wr_en_b = 1'b0, reinit_b = 1'b0;
    logic [6:0] wr_addr_b = '0;
    logic [7:0] wr_data_b = '0;
    logic       rs_a, rw_a, e_a, idn_a, fd_a;
    logic [7:0] data_a;
    logic       rs_b, rw_b, e_b, idn_b, fd_b;
    logic [7:0] data_b;

    int checks = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    lcd_frame_driver u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .reinit(reinit_a), .LCD_RS(rs_a), .LCD_RW(rw_a), .LCD_E(e_a), .LCD_DATA(data_a),
        .init_done(idn_a), .frame_done(fd_a)
    );

    lcd_frame_driver #(
        .CLK_DIV(6), .E_HIGH(3), .COLS(20), .ROWS(4), .PWR_WAIT(2), .CLR_WAIT(1)
    ) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .reinit(reinit_b), .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_E(e_b), .LCD_DATA(data_b),
        .init_done(idn_b), .frame_done(fd_b)
    );

    // Reference model: the bus is a function of the step number since reset/reinit and a buffer snapshot.
    int p_div [2] = '{3, 6};
    int p_eh  [2] = '{1, 3};
    int p_cols[2] = '{16, 20};
    int p_rows[2] = '{2, 4};
    int p_pwr [2] = '{4, 2};
    int p_clr [2] = '{2, 1};
    logic [7:0] bases [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    int         md [2];
    int         ms [2];
    bit         pend [2];
    bit         mfd [2];
    logic [8:0] mexp [2];
    logic [7:0] mbuf [2][80];
    bit         mon_en = 0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] trans(input int i, input int s);
        int len, flen, p, r, c, k;
        len  = 5 + p_clr[i];
        flen = p_rows[i] * (p_cols[i] + 1);
        if (s < p_pwr[i]) return 9'h000;
        if (s < p_pwr[i] + len) begin
            k = s - p_pwr[i];
            if (k == len - 1) return 9'h006;
            if (k >= 3) return 9'h001;
            if (k == 2) return 9'h00C;
            return 9'h038;
        end
        p = (s - p_pwr[i] - len) % flen;
        r = p / (p_cols[i] + 1);
        c = p % (p_cols[i] + 1);
        if (c == 0) return {1'b0, bases[r]};
        return {1'b1, mbuf[i][r * p_cols[i] + c - 1]};
    endfunction

    function automatic bit last_cell(input int i, input int s);
        int len, flen;
        len  = 5 + p_clr[i];
        flen = p_rows[i] * (p_cols[i] + 1);
        if (s < p_pwr[i] + len) return 1'b0;
        return ((s - p_pwr[i] - len) % flen) == flen - 1;
    endfunction

    task automatic model_edge(input int i, input logic r, input logic we, input int addr,
                              input logic [7:0] d, input logic ri);
        bit pn;
        if (r) begin
            md[i] = 0; ms[i] = 0; pend[i] = 0; mfd[i] = 0;
            for (int j = 0; j < 80; j++) mbuf[i][j] = 8'h20;
            mexp[i] = trans(i, 0);
            return;
        end
        pn     = pend[i] | ri;
        md[i]  = (md[i] + 1) % p_div[i];
        mfd[i] = 0;
        if (md[i] == 0) begin
            ms[i]   = pn ? p_pwr[i] : ms[i] + 1;
            pend[i] = 0;
            mexp[i] = trans(i, ms[i]);
            mfd[i]  = last_cell(i, ms[i]);
        end else begin
            pend[i] = pn;
        end
        if (we && addr < p_rows[i] * p_cols[i]) mbuf[i][addr] = d;
    endtask

    task automatic mon(input int i, input logic rs, input logic [7:0] data, input logic e,
                       input logic rw, input logic idn, input logic fd);
        string n;
        n = (i == 0) ? "a" : "b";
        check({n, "_rs"},         32'(rs),   32'(mexp[i][8]));
        check({n, "_data"},       32'(data), 32'(mexp[i][7:0]));
        check({n, "_e"},          32'(e),    32'(md[i] >= 1 && md[i] <= p_eh[i]));
        check({n, "_rw"},         32'(rw),   32'(0));
        check({n, "_init_done"},  32'(idn),  32'(ms[i] >= p_pwr[i] + 5 + p_clr[i]));
        check({n, "_frame_done"}, 32'(fd),   32'(mfd[i]));
    endtask

    initial forever begin
        @(posedge clk);
        model_edge(0, rst, wr_en_a, int'(wr_addr_a), wr_data_a, reinit_a);
        model_edge(1, rst, wr_en_b, int'(wr_addr_b), wr_data_b, reinit_b);
        cyc++;
        mon_en = 1;
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            mon(0, rs_a, data_a, e_a, rw_a, idn_a, fd_a);
            mon(1, rs_b, data_b, e_b, rw_b, idn_b, fd_b);
        end
    end

    initial begin
        int n, t1, t2;
        logic [7:0] last;
        repeat (3) @(negedge clk);
        check("rst_data_a", 32'(data_a), 32'h00);
        check("rst_e_b",    32'(e_b),    32'(0));
        check("rst_idn_a",  32'(idn_a),  32'(0));
        rst = 1'b0;

        // Untouched buffer: two consecutive frame_done pulses 34 steps apart.
        n = 0;
        while (!fd_a && n < 400) begin @(negedge clk); n++; end
        check("wait_fd1_a", 32'(fd_a), 32'(1));
        t1 = cyc;
        @(negedge clk);
        n = 0;
        while (!fd_a && n < 400) begin @(negedge clk); n++; end
        check("wait_fd2_a", 32'(fd_a), 32'(1));
        t2 = cyc;
        check("frame_period_a", 32'(t2 - t1), 32'(102));
        check("init_done_a", 32'(idn_a), 32'(1));

        for (int k = 0; k < 800; k++) begin
            wr_en_a   = ($urandom_range(0, 3) == 0);
            wr_addr_a = 5'($urandom_range(0, 31));
            wr_data_a = 8'($urandom);
            wr_en_b   = ($urandom_range(0, 3) == 0);
            wr_addr_b = 7'($urandom_range(0, 127));
            wr_data_b = 8'($urandom);
            reinit_a  = ($urandom_range(0, 499) == 0);
            reinit_b  = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        wr_en_a = 1'b0; wr_en_b = 1'b0; reinit_a = 1'b0; reinit_b = 1'b0;

        wr_en_b = 1'b1; wr_addr_b = 7'd79; wr_data_b = 8'h41;
        @(negedge clk);
        wr_addr_b = 7'd20; wr_data_b = 8'h42;
        @(negedge clk);
        wr_addr_b = 7'd100; wr_data_b = 8'h99;
        @(negedge clk);
        wr_en_b = 1'b0;

        n = 0;
        while (!(rs_b == 1'b0 && data_b == 8'hC0) && n < 1500) begin @(negedge clk); n++; end
        check("wait_row1_b", 32'(data_b), 32'hC0);
        n = 0;
        while (!rs_b && n < 20) begin @(negedge clk); n++; end
        check("row1_first_char_b", 32'(data_b), 32'h42);

        n = 0;
        while (!(rs_b == 1'b0 && data_b == 8'hD4) && n < 1500) begin @(negedge clk); n++; end
        check("wait_row3_b", 32'(data_b), 32'hD4);
        last = 8'h00;
        n = 0;
        while (!(rs_b == 1'b0 && data_b != 8'hD4) && n < 200) begin
            if (rs_b) last = data_b;
            @(negedge clk); n++;
        end
        check("row3_last_char_b", 32'(last), 32'h41);

        n = 0;
        while (!(rs_a == 1'b0 && data_a == 8'hC0) && n < 400) begin @(negedge clk); n++; end
        check("wait_row1_a", 32'(data_a), 32'hC0);
        repeat (4) @(negedge clk);
        reinit_a = 1'b1;
        @(negedge clk);
        reinit_a = 1'b0;
        n = 0;
        while (idn_a && n < 6) begin @(negedge clk); n++; end
        check("reinit_idn_a",  32'(idn_a),  32'(0));
        check("reinit_data_a", 32'(data_a), 32'h38);
        check("reinit_rs_a",   32'(rs_a),   32'(0));
        n = 0;
        while (!idn_a && n < 100) begin @(negedge clk); n++; end
        check("reinit_done_a", 32'(idn_a), 32'(1));

        n = 0;
        while (!fd_a && n < 400) begin @(negedge clk); n++; end
        check("wait_fd3_a", 32'(fd_a), 32'(1));
        reinit_a = 1'b1;
        @(negedge clk);
        reinit_a = 1'b0;
        repeat (250) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        check("midrst_idn_a", 32'(idn_a), 32'(0));
        check("midrst_fd_b",  32'(fd_b),  32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
